// File: rtl/if_stage_if.sv
// if_stage_if: bus bundle between the fetch stage, instruction memory,
// the decoder and the hazard/branch logic.
// master = fetch stage, slave = the surrounding pipeline/memory.
interface if_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, halted, fetch_count,
    input  imem_data, stall, redirect_valid, redirect_pc, halt_req
  );

  modport slave (
    input  imem_addr, id_valid, id_pc, id_pc_plus4, id_instr, halted, fetch_count,
    output imem_data, stall, redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, addresses the
// combinational instruction memory and captures the returned word into the
// IF/ID register. Handles stall, redirect (branch/jump) and halt.
// Optional feature: define IF_FETCH_COUNT_EN to enable the saturating
// accepted-fetch counter on fetch_count; otherwise it is tied to zero.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst_n,
  if_stage_if.master bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_plus4_q;
  logic [31:0] id_instr_q;
  logic        halted_q;

  logic [31:0] pc_plus4_d;
  logic [31:0] redirect_pc_d;
  logic        advance_d;

  // Target low bits are dropped: fetch addresses are always word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign pc_plus4_d    = pc_q + 32'd4;
  assign redirect_pc_d = {bus.redirect_pc[31:2], 2'b00};
  // An accepted fetch: running with no redirect, halt or stall this cycle.
  assign advance_d     = (state_q == S_RUN) && !bus.redirect_valid &&
                         !bus.halt_req && !bus.stall;

  // Fetch FSM together with PC and IF/ID pipeline register updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC_ALIGNED;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
      id_instr_q    <= 32'h0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          // Single bubble; redirects arriving now are ignored.
          pc_q     <= RESET_PC_ALIGNED;
          state_q  <= S_RUN;
          halted_q <= 1'b0;
        end
        S_RUN: begin
          if (bus.redirect_valid) begin
            // Squash the wrong-path instruction even if decode is stalled.
            pc_q       <= redirect_pc_d;
            id_valid_q <= 1'b0;
          end else if (bus.halt_req) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            if (!bus.stall) begin
              id_valid_q <= 1'b0;
            end
          end else if (!bus.stall) begin
            id_instr_q    <= bus.imem_data;
            id_pc_q       <= pc_q;
            id_pc_plus4_q <= pc_plus4_d;
            id_valid_q    <= 1'b1;
            pc_q          <= pc_plus4_d;
          end
        end
        S_HALT: begin
          if (!bus.stall) begin
            id_valid_q <= 1'b0;
          end
          if (bus.redirect_valid) begin
            pc_q <= redirect_pc_d;
          end
          if (!bus.halt_req) begin
            // Resume fetching from whatever PC we hold now.
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_BOOT;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetch_count_q;

  // Count accepted fetches, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= 32'h0;
    end else if (advance_d && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_count_q;
`else
  logic unused_advance;
  assign unused_advance  = advance_d;
  assign bus.fetch_count = 32'h0;
`endif

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_plus4_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test of if_stage with a small combinational
// instruction memory and hand-computed expected values.
`timescale 1ns/1ps
module tb_if_stage;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: fixed words at 0/4/8, inverted address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1111_1111;
      32'h4:   return 32'h2222_2222;
      32'h8:   return 32'h3333_3333;
      default: return ~a;
    endcase
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  // Expected counter value for the current build.
  function automatic logic [31:0] exp_cnt(input int n);
`ifdef IF_FETCH_COUNT_EN
    return n;
`else
    return (n < 0) ? 32'h1 : 32'h0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".addr"},  bus.imem_addr,   32'h0);
    check({tag, ".valid"}, {31'h0, bus.id_valid}, 32'h0);
    check({tag, ".pc"},    bus.id_pc,       32'h0);
    check({tag, ".pc4"},   bus.id_pc_plus4, 32'h0);
    check({tag, ".instr"}, bus.id_instr,    32'h0);
    check({tag, ".halt"},  {31'h0, bus.halted}, 32'h0);
    check({tag, ".cnt"},   bus.fetch_count, 32'h0);
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    rst_n              = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.halt_req       = 1'b0;

    // Phase A: power-on reset and straight-line fetch.
    #12;
    check_reset_vals("por");
    rst_n = 1'b1;
    step();
    check("boot.valid", {31'h0, bus.id_valid}, 32'h0);
    check("boot.addr",  bus.imem_addr, 32'h0);
    step();
    check("e2.instr", bus.id_instr,    32'h1111_1111);
    check("e2.pc",    bus.id_pc,       32'h0);
    check("e2.pc4",   bus.id_pc_plus4, 32'h4);
    check("e2.valid", {31'h0, bus.id_valid}, 32'h1);
    step();
    check("e3.instr", bus.id_instr,    32'h2222_2222);
    check("e3.pc",    bus.id_pc,       32'h4);
    check("e3.pc4",   bus.id_pc_plus4, 32'h8);
    step();
    check("e4.instr", bus.id_instr,    32'h3333_3333);
    check("e4.pc",    bus.id_pc,       32'h8);
    check("e4.pc4",   bus.id_pc_plus4, 32'hC);
    check("e4.cnt",   bus.fetch_count, exp_cnt(3));

    // Phase B: asynchronous reset between edges, no clock edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    #1;
    rst_n = 1'b1;
    // A redirect during BOOT must be ignored.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    step();
    check("bootredir.addr", bus.imem_addr, 32'h0);
    bus.redirect_valid = 1'b0;
    step();
    step();
    check("r3.pc",   bus.id_pc,     32'h4);
    check("r3.addr", bus.imem_addr, 32'h8);

    // Stall for three cycles with id_pc = 4.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d.addr", i),  bus.imem_addr, 32'h8);
      check($sformatf("stall%0d.instr", i), bus.id_instr,  32'h2222_2222);
      check($sformatf("stall%0d.valid", i), {31'h0, bus.id_valid}, 32'h1);
      check($sformatf("stall%0d.cnt", i),   bus.fetch_count, exp_cnt(2));
    end

    // Redirect during stall: squash, aligned target, data fields hold.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    step();
    check("redir.valid", {31'h0, bus.id_valid}, 32'h0);
    check("redir.addr",  bus.imem_addr, 32'h40);
    check("redir.instr", bus.id_instr,  32'h2222_2222);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    step();
    check("tgt.pc",    bus.id_pc,    32'h40);
    check("tgt.valid", {31'h0, bus.id_valid}, 32'h1);
    check("tgt.instr", bus.id_instr, 32'hFFFF_FFBF);
    check("tgt.cnt",   bus.fetch_count, exp_cnt(3));

    // Phase C: PC wrap-around.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    step();
    check("wrapredir.addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    step();
    check("wrap.addr", bus.imem_addr,   32'h0);
    check("wrap.pc",   bus.id_pc,       32'hFFFF_FFFC);
    check("wrap.pc4",  bus.id_pc_plus4, 32'h0);
    check("wrap.instr", bus.id_instr,   32'h0000_0003);

    // Phase D: halt, redirect while halted, resume.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    step();
    bus.redirect_valid = 1'b0;
    bus.halt_req       = 1'b1;
    step();
    check("halt.halted", {31'h0, bus.halted}, 32'h1);
    check("halt.valid",  {31'h0, bus.id_valid}, 32'h0);
    check("halt.addr",   bus.imem_addr, 32'h10);
    step();
    check("halt2.addr",  bus.imem_addr, 32'h10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    step();
    check("haltredir.addr",   bus.imem_addr, 32'h20);
    check("haltredir.halted", {31'h0, bus.halted}, 32'h1);
    bus.redirect_valid = 1'b0;
    bus.halt_req       = 1'b0;
    step();
    check("resume.halted", {31'h0, bus.halted}, 32'h0);
    check("resume.valid",  {31'h0, bus.id_valid}, 32'h0);
    step();
    check("resume.pc",    bus.id_pc, 32'h20);
    check("resume.valid2", {31'h0, bus.id_valid}, 32'h1);
    check("resume.instr", bus.id_instr, 32'hFFFF_FFDF);
    check("final.cnt",    bus.fetch_count, exp_cnt(5));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
